upg_word_loader: RTL and testbench



---
 rtl/upg_word_loader.sv | 210 +++++++++++++++++++++
 tb/tb_upg_word_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/upg_word_loader.sv
// -----------------------------------------------------------------------------
// upg_word_loader
//
// Upstream feeder for the UART program-update path. Waits in IDLE for a sync
// byte, then assembles little-endian 32-bit words from the received byte stream.
// Each completed word is emitted as a single-cycle write strobe carrying a word
// address. Instruction memory is filled first (region 0), then data memory
// (region 1). When the last data word has been written, or when the byte
// stream goes quiet for too long, the loader raises upg_done_o. This flag hands
// both memories back to the CPU.
//
// Optional feature (macro UPG_CHECKSUM_EN): after the final data word, one extra
// byte is compared with the running XOR of all payload bytes. A mismatch or a
// timeout while waiting for that byte sets upg_err_o.
//
// Parameters:
//   IMEM_WORDS      words written to instruction memory (1..16384)
//   DMEM_WORDS      words written to data memory (1..16384)
//   TIMEOUT_CYCLES  idle cycles without a byte before the load ends early (>= 2)
//   SYNC_BYTE       start-of-load marker
//
// Ports:
//   upg_clk_i    loader clock
//   upg_rst_n_i  asynchronous active-low reset
//   rx_valid_i   one-cycle pulse, rx_data_i holds a received byte
//   rx_data_i    received byte
//   upg_wen_o    one-cycle word write strobe
//   upg_adr_o    [14] region (0 = instruction, 1 = data), [13:0] word index
//   upg_dat_o    assembled word, held until the next write
//   upg_done_o   load finished, memories belong to the CPU
//   upg_busy_o   load in progress
//   upg_err_o    checksum error (constant 0 without UPG_CHECKSUM_EN)
// -----------------------------------------------------------------------------
module upg_word_loader #(
  parameter int unsigned IMEM_WORDS     = 16384,
  parameter int unsigned DMEM_WORDS     = 16384,
  parameter int unsigned TIMEOUT_CYCLES = 10000000,
  parameter logic [7:0]  SYNC_BYTE      = 8'h55
) (
  input  logic        upg_clk_i,
  input  logic        upg_rst_n_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        upg_busy_o,
  output logic        upg_err_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [13:0]   IMEM_LAST = 14'(IMEM_WORDS - 1);
  localparam logic [13:0]   DMEM_LAST = 14'(DMEM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
`ifdef UPG_CHECKSUM_EN
    CHECK = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [1:0]    byte_cnt;
  logic [31:0]   asm_word;   // assembly register, independent of upg_dat_o
  logic [13:0]   word_idx;
  logic          region;
  logic [TW-1:0] to_cnt;
`ifdef UPG_CHECKSUM_EN
  logic [7:0]    xor_acc;
  logic          err_q;
`endif

  logic sync_seen;
  logic final_wr;
  logic timeout;

  assign sync_seen = rx_valid_i && (rx_data_i == SYNC_BYTE);
  // The index advances in the strobe cycle. At that point region/word_idx
  // still name the word being written, so the last strobe is identified here.
  assign final_wr  = upg_wen_o && region && (word_idx == DMEM_LAST);
  assign timeout   = !rx_valid_i && (to_cnt == TO_LAST);

  // State register
  always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
    // NOTE: state is updated with non-blocking assignments so that every
    // register samples values from before the clock edge.
    if (!upg_rst_n_i) state <= IDLE;
    else              state <= state_next;
  end

  // Next-state logic
  always_comb begin
    // NOTE: the default comes first, so no path leaves state_next unassigned
    // and no latch is inferred.
    state_next = state;
    case (state)
      IDLE: if (sync_seen) state_next = LOAD;
      LOAD: begin
        if (final_wr) begin
`ifdef UPG_CHECKSUM_EN
          // A byte arriving in the final strobe cycle is already the check byte.
          state_next = rx_valid_i ? DONE : CHECK;
`else
          state_next = DONE;
`endif
        end else if (timeout) begin
          state_next = DONE;
        end
      end
`ifdef UPG_CHECKSUM_EN
      CHECK: if (rx_valid_i || timeout) state_next = DONE;
`endif
      DONE: if (sync_seen) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // Datapath, counters and registered outputs
  always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
    if (!upg_rst_n_i) begin
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
      upg_done_o <= 1'b0;
      upg_busy_o <= 1'b0;
      byte_cnt   <= '0;
      asm_word   <= '0;
      word_idx   <= '0;
      region     <= 1'b0;
      to_cnt     <= '0;
`ifdef UPG_CHECKSUM_EN
      xor_acc    <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      upg_wen_o  <= 1'b0;
      upg_done_o <= (state_next == DONE);
`ifdef UPG_CHECKSUM_EN
      upg_busy_o <= (state_next == LOAD) || (state_next == CHECK);
`else
      upg_busy_o <= (state_next == LOAD);
`endif
      case (state)
        IDLE, DONE: begin
          if (sync_seen) begin
            byte_cnt <= '0;
            word_idx <= '0;
            region   <= 1'b0;
            to_cnt   <= '0;
`ifdef UPG_CHECKSUM_EN
            xor_acc  <= '0;
            err_q    <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (upg_wen_o) begin
            if (!region && (word_idx == IMEM_LAST)) begin
              region   <= 1'b1;
              word_idx <= '0;
            end else begin
              word_idx <= word_idx + 14'd1;
            end
          end
          if (final_wr) begin
            to_cnt <= '0;
`ifdef UPG_CHECKSUM_EN
            if (rx_valid_i) err_q <= (rx_data_i != xor_acc);
`endif
          end else if (rx_valid_i) begin
            to_cnt   <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            asm_word[{byte_cnt, 3'b000} +: 8] <= rx_data_i;
`ifdef UPG_CHECKSUM_EN
            xor_acc  <= xor_acc ^ rx_data_i;
`endif
            if (byte_cnt == 2'd3) begin
              upg_wen_o <= 1'b1;
              upg_adr_o <= {region, word_idx};
              upg_dat_o <= {rx_data_i, asm_word[23:0]};
            end
          end else begin
            // On timeout a partial word stays in asm_word. It is never
            // strobed, and the next restart clears byte_cnt.
            to_cnt <= to_cnt + 1'b1;
          end
        end
`ifdef UPG_CHECKSUM_EN
        CHECK: begin
          if (rx_valid_i)   err_q  <= (rx_data_i != xor_acc);
          else if (timeout) err_q  <= 1'b1;
          else              to_cnt <= to_cnt + 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef UPG_CHECKSUM_EN
  assign upg_err_o = err_q;
`else
  assign upg_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_upg_word_loader.sv
// -----------------------------------------------------------------------------
// tb_upg_word_loader
//
// Directed testbench for upg_word_loader with IMEM_WORDS=4, DMEM_WORDS=2 and
// TIMEOUT_CYCLES=50. Inputs change on the falling edge. Outputs are sampled on
// the falling edge, and a monitor records every write strobe together with its
// cycle number. The checksum tests are compiled only when UPG_CHECKSUM_EN is
// defined.
// -----------------------------------------------------------------------------
module tb_upg_word_loader;

`ifdef UPG_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        wen;
  logic [14:0] adr;
  logic [31:0] dat;
  logic        done;
  logic        busy;
  logic        err;

  upg_word_loader #(
    .IMEM_WORDS    (4),
    .DMEM_WORDS    (2),
    .TIMEOUT_CYCLES(50),
    .SYNC_BYTE     (8'h55)
  ) dut (
    .upg_clk_i  (clk),
    .upg_rst_n_i(rst_n),
    .rx_valid_i (rx_valid),
    .rx_data_i  (rx_data),
    .upg_wen_o  (wen),
    .upg_adr_o  (adr),
    .upg_dat_o  (dat),
    .upg_done_o (done),
    .upg_busy_o (busy),
    .upg_err_o  (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [14:0] adr;
    logic [31:0] dat;
    int          cyc;
  } strobe_t;

  strobe_t sq[$];

  always @(posedge clk) begin
    #1;
    if (wen === 1'b1) sq.push_back('{adr, dat, cyc});
  end

  int compared   = 0;
  int mismatched = 0;
  int last_cyc   = 0;
  int sync_cyc   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge; returns on the next falling edge.
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    last_cyc = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sq.delete();
  endtask

  logic [14:0] exp2_adr [6] = '{15'h0000, 15'h0001, 15'h0002, 15'h0003, 15'h4000, 15'h4001};
  logic [31:0] exp2_dat [6] = '{32'h03020100, 32'h07060504, 32'h0b0a0908,
                                32'h0f0e0d0c, 32'h13121110, 32'h17161514};
  logic [31:0] exp4_dat [6] = '{32'h23222120, 32'h27262524, 32'h2b2a2928,
                                32'h2f2e2d2c, 32'h33323130, 32'h37363534};

  initial begin
    // ---- Reset values ----
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_wen",  wen,  1'b0);
    check("rst_adr",  adr,  15'h0);
    check("rst_dat",  dat,  32'h0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err",  err,  1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- Test 1: non-sync byte ignored, first word ----
    send(8'h12);
    check("t1_idle_busy", busy, 1'b0);
    send(8'h55);
    check("t1_sync_busy", busy, 1'b1);
    send(8'h78);
    send(8'h56);
    send(8'h34);
    send(8'h12);
    check("t1_wen_now", wen, 1'b1);
    check("t1_count", sq.size(), 1);
    if (sq.size() > 0) begin
      check("t1_adr", sq[0].adr, 15'h0000);
      check("t1_dat", sq[0].dat, 32'h12345678);
      check("t1_latency", sq[0].cyc, last_cyc + 1);
    end
    idle(1);
    check("t1_wen_single", wen, 1'b0);

    // ---- Test 2: full load with gaps, region switch, done timing ----
    do_reset();
    send(8'h55);
    for (int i = 0; i < 24; i++) begin
      send(8'(i));
      if (i != 23) idle(1);
    end
    check("t2_last_wen", wen, 1'b1);
    check("t2_done_during_strobe", done, 1'b0);
    idle(1);
    check("t2_done_after", done, !CK);
    check("t2_busy_after", busy, CK);
    check("t2_count", sq.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (sq.size() > k) begin
        check($sformatf("t2_adr%0d", k), sq[k].adr, exp2_adr[k]);
        check($sformatf("t2_dat%0d", k), sq[k].dat, exp2_dat[k]);
      end
    end

    // ---- Test 3: timeout discards a partial word ----
    do_reset();
    send(8'h55);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    send(8'h99);
    send(8'h88);
    idle(49);
    check("t3_done_before_timeout", done, 1'b0);
    idle(1);
    check("t3_done_at_timeout", done, 1'b1);
    check("t3_busy_at_timeout", busy, 1'b0);
    check("t3_count", sq.size(), 1);
    if (sq.size() > 0) begin
      check("t3_adr", sq[0].adr, 15'h0000);
      check("t3_dat", sq[0].dat, 32'h44332211);
    end
    send(8'hAA);
    idle(2);
    check("t3_done_held", done, 1'b1);
    check("t3_count_after_aa", sq.size(), 1);

    // ---- Test 4: back-to-back bytes, 9 words offered ----
    do_reset();
    send(8'h55);
    sync_cyc = last_cyc;
    for (int i = 0; i < 36; i++) send(8'(8'h20 + i));
    idle(2);
    check("t4_count", sq.size(), 6);
    check("t4_done", done, 1'b1);
    if (sq.size() > 0) check("t4_first_cyc", sq[0].cyc, sync_cyc + 5);
    for (int k = 0; k < 6; k++) begin
      if (sq.size() > k) begin
        check($sformatf("t4_adr%0d", k), sq[k].adr, exp2_adr[k]);
        check($sformatf("t4_dat%0d", k), sq[k].dat, exp4_dat[k]);
        if (k > 0) check($sformatf("t4_gap%0d", k), sq[k].cyc - sq[k-1].cyc, 4);
      end
    end

    // ---- Test 5: restart from DONE, then reset mid-word ----
    sq.delete();
    send(8'h55);
    check("t5_restart_done", done, 1'b0);
    check("t5_restart_busy", busy, 1'b1);
    check("t5_adr_held", adr, 15'h4001);
    check("t5_dat_held", dat, 32'h37363534);
    send(8'hA1);
    send(8'hA2);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_adr",  adr,  15'h0);
    check("t5_rst_dat",  dat,  32'h0);
    check("t5_rst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h55);
    send(8'hDE);
    send(8'hAD);
    send(8'hBE);
    send(8'hEF);
    check("t5_count", sq.size(), 1);
    if (sq.size() > 0) begin
      check("t5_adr", sq[0].adr, 15'h0000);
      check("t5_dat", sq[0].dat, 32'hEFBEADDE);
    end

`ifdef UPG_CHECKSUM_EN
    // ---- Checksum: XOR of payload bytes 0x00..0x17 is 0x00 ----
    do_reset();
    send(8'h55);
    for (int i = 0; i < 24; i++) send(8'(i));
    idle(2);
    check("ck_wait_done", done, 1'b0);
    send(8'h00);
    check("ck_good_done", done, 1'b1);
    check("ck_good_err",  err,  1'b0);
    send(8'h55);
    for (int i = 0; i < 24; i++) send(8'(i));
    idle(2);
    send(8'h01);
    check("ck_bad_done", done, 1'b1);
    check("ck_bad_err",  err,  1'b1);
    send(8'h55);
    check("ck_restart_done", done, 1'b0);
    check("ck_restart_err",  err,  1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
